// File: rtl/axi_txn_snoop_recorder.sv
// axi_txn_snoop_recorder: passive AXI4 snooper that condenses each completed write/read burst into one record
//   aclk/areset          : clock, asynchronous active-high reset
//   aw*/w*/b*/ar*/r*     : observed AXI4 handshake signals (inputs only, nothing is driven onto the bus)
//   rec_valid/rec_ready  : record FIFO head valid / consumer pop; rec_* show the head (first-word fall-through)
//   err_proto/err_ovf    : sticky protocol error / record drop; drop_cnt saturating drop count; err_clr clears all three
//   TXN_TIMESTAMP_EN     : when defined, records carry the free-running cycle count sampled at the AW/AR beat
module axi_txn_snoop_q #(
  parameter int W = 8,
  parameter int D = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_empty,
  output logic         o_full
);
  localparam int AW = D > 1 ? $clog2(D) : 1;
  localparam logic [AW-1:0] LAST = AW'(D - 1);
  logic [W-1:0] r_mem [D];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_cnt;
  logic w_push, w_pop;
  assign o_empty = r_cnt == '0;
  assign o_full = r_cnt == (AW+1)'(D);
  assign w_push = i_push && !o_full;
  assign w_pop = i_pop && !o_empty;
  assign o_data = r_mem[r_rp];
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp == LAST ? '0 : r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp == LAST ? '0 : r_rp + 1'b1;
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  always_ff @(posedge i_clk)
    if (w_push) r_mem[r_wp] <= i_data;
endmodule

module axi_txn_snoop_recorder #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int CMD_DEPTH  = 4,
  parameter int REC_DEPTH  = 8
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  awvalid,
  input  logic                  awready,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic [7:0]            awlen,
  input  logic [ID_WIDTH-1:0]   awid,
  input  logic                  wvalid,
  input  logic                  wready,
  input  logic                  wlast,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  bvalid,
  input  logic                  bready,
  input  logic [1:0]            bresp,
  input  logic [ID_WIDTH-1:0]   bid,
  input  logic                  arvalid,
  input  logic                  arready,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic [7:0]            arlen,
  input  logic [ID_WIDTH-1:0]   arid,
  input  logic                  rvalid,
  input  logic                  rready,
  input  logic                  rlast,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            rresp,
  input  logic [ID_WIDTH-1:0]   rid,
  output logic                  rec_valid,
  input  logic                  rec_ready,
  output logic                  rec_is_read,
  output logic [ADDR_WIDTH-1:0] rec_addr,
  output logic [7:0]            rec_len,
  output logic [ID_WIDTH-1:0]   rec_id,
  output logic [1:0]            rec_resp,
  output logic [8:0]            rec_beats,
  output logic [31:0]           rec_csum,
  output logic [31:0]           rec_ts,
  output logic                  err_proto,
  output logic                  err_ovf,
  output logic [15:0]           drop_cnt,
  input  logic                  err_clr
);
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            len;
    logic [ID_WIDTH-1:0]   id;
    logic [31:0]           ts;
  } cmd_t;
  typedef struct packed {
    logic [8:0]  beats;
    logic [31:0] csum;
  } wsum_t;
  typedef struct packed {
    logic                  is_read;
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            len;
    logic [ID_WIDTH-1:0]   id;
    logic [1:0]            resp;
    logic [8:0]            beats;
    logic [31:0]           csum;
    logic [31:0]           ts;
  } rec_t;
  localparam int RW = $clog2(REC_DEPTH);
  function automatic logic [31:0] fold(input logic [DATA_WIDTH-1:0] d);
    fold = '0;
    for (int i = 0; i < DATA_WIDTH / 32; i++) fold ^= d[i*32 +: 32];
  endfunction
  logic w_aw, w_w, w_b, w_ar, w_r, w_rl;
  logic [31:0] w_ts;
  cmd_t w_awq, w_arq;
  wsum_t w_wsq;
  logic w_awq_e, w_awq_f, w_wsq_e, w_wsq_f, w_arq_e, w_arq_f;
  logic [8:0] r_wcnt, r_rcnt;
  logic [31:0] r_wcsum, r_rcsum;
  logic [1:0] r_rresp;
  rec_t w_wrec, w_rrec, w_head;
  logic w_werr, w_rerr, w_qerr;
  rec_t r_mem [REC_DEPTH];
  logic [RW-1:0] r_fwp, r_frp;
  logic [RW:0] r_fcnt;
  logic [RW+1:0] w_free;
  logic w_pop, w_wacc, w_racc;
  logic [1:0] w_ndrop;
  logic [16:0] w_dsum;
  logic r_err_proto, r_err_ovf;
  logic [15:0] r_drop;
  assign w_aw = awvalid && awready;
  assign w_w = wvalid && wready;
  assign w_b = bvalid && bready;
  assign w_ar = arvalid && arready;
  assign w_r = rvalid && rready;
  assign w_rl = w_r && rlast;
`ifdef TXN_TIMESTAMP_EN
  logic [31:0] r_ts;
  always_ff @(posedge aclk or posedge areset)
    if (areset) r_ts <= '0;
    else r_ts <= r_ts + 1'b1;
  assign w_ts = r_ts;
`else
  assign w_ts = '0;
`endif
  axi_txn_snoop_q #(.W($bits(cmd_t)), .D(CMD_DEPTH)) u_awq (
    .i_clk(aclk), .i_rst(areset), .i_push(w_aw), .i_data({awaddr, awlen, awid, w_ts}),
    .i_pop(w_b), .o_data(w_awq), .o_empty(w_awq_e), .o_full(w_awq_f));
  axi_txn_snoop_q #(.W($bits(wsum_t)), .D(CMD_DEPTH)) u_wsq (
    .i_clk(aclk), .i_rst(areset), .i_push(w_w && wlast), .i_data({r_wcnt + 9'd1, r_wcsum ^ fold(wdata)}),
    .i_pop(w_b), .o_data(w_wsq), .o_empty(w_wsq_e), .o_full(w_wsq_f));
  axi_txn_snoop_q #(.W($bits(cmd_t)), .D(CMD_DEPTH)) u_arq (
    .i_clk(aclk), .i_rst(areset), .i_push(w_ar), .i_data({araddr, arlen, arid, w_ts}),
    .i_pop(w_rl), .o_data(w_arq), .o_empty(w_arq_e), .o_full(w_arq_f));
  // A missing command or data summary still yields a record, with zeroed beats/csum.
  always_comb begin
    w_wrec = '0;
    w_wrec.addr = w_awq_e ? '0 : w_awq.addr;
    w_wrec.len = w_awq_e ? '0 : w_awq.len;
    w_wrec.ts = w_awq_e ? '0 : w_awq.ts;
    w_wrec.id = bid;
    w_wrec.resp = bresp;
    w_wrec.beats = w_awq_e || w_wsq_e ? '0 : w_wsq.beats;
    w_wrec.csum = w_awq_e || w_wsq_e ? '0 : w_wsq.csum;
    w_werr = w_b && (w_awq_e || w_wsq_e || bid != w_awq.id || w_wsq.beats != {1'b0, w_awq.len} + 9'd1);
    w_rrec = '0;
    w_rrec.is_read = 1'b1;
    w_rrec.addr = w_arq_e ? '0 : w_arq.addr;
    w_rrec.len = w_arq_e ? '0 : w_arq.len;
    w_rrec.ts = w_arq_e ? '0 : w_arq.ts;
    w_rrec.id = rid;
    w_rrec.resp = rresp > r_rresp ? rresp : r_rresp;
    w_rrec.beats = r_rcnt + 9'd1;
    w_rrec.csum = r_rcsum ^ fold(rdata);
    w_rerr = w_rl && (w_arq_e || rid != w_arq.id || w_rrec.beats != {1'b0, w_arq.len} + 9'd1);
  end
  assign w_qerr = (w_aw && w_awq_f) || (w_w && wlast && w_wsq_f) || (w_ar && w_arq_f);
  // Space check counts the slot freed by a same-cycle pop; the write record claims space first.
  assign w_pop = rec_ready && r_fcnt != '0;
  assign w_free = (RW+2)'(REC_DEPTH) - (RW+2)'(r_fcnt) + (RW+2)'(w_pop);
  assign w_wacc = w_b && w_free != '0;
  assign w_racc = w_rl && w_free > (RW+2)'(w_wacc);
  assign w_ndrop = 2'(w_b && !w_wacc) + 2'(w_rl && !w_racc);
  assign w_dsum = {1'b0, r_drop} + 17'(w_ndrop);
  always_ff @(posedge aclk or posedge areset)
    if (areset) begin
      r_wcnt <= '0;
      r_wcsum <= '0;
      r_rcnt <= '0;
      r_rcsum <= '0;
      r_rresp <= '0;
      r_fwp <= '0;
      r_frp <= '0;
      r_fcnt <= '0;
      r_err_proto <= 1'b0;
      r_err_ovf <= 1'b0;
      r_drop <= '0;
    end else begin
      if (w_w) begin
        r_wcnt <= wlast ? '0 : r_wcnt + 9'd1;
        r_wcsum <= wlast ? '0 : r_wcsum ^ fold(wdata);
      end
      if (w_r) begin
        r_rcnt <= rlast ? '0 : w_rrec.beats;
        r_rcsum <= rlast ? '0 : w_rrec.csum;
        r_rresp <= rlast ? '0 : w_rrec.resp;
      end
      r_fwp <= r_fwp + RW'(w_wacc) + RW'(w_racc);
      r_frp <= r_frp + RW'(w_pop);
      r_fcnt <= r_fcnt + (RW+1)'(w_wacc) + (RW+1)'(w_racc) - (RW+1)'(w_pop);
      r_err_proto <= (r_err_proto && !err_clr) || w_werr || w_rerr || w_qerr;
      r_err_ovf <= (r_err_ovf && !err_clr) || w_ndrop != '0;
      r_drop <= err_clr ? 16'(w_ndrop) : w_dsum[16] ? 16'hFFFF : w_dsum[15:0];
    end
  always_ff @(posedge aclk) begin
    if (w_wacc) r_mem[r_fwp] <= w_wrec;
    if (w_racc) r_mem[r_fwp + RW'(w_wacc)] <= w_rrec;
  end
  assign w_head = r_fcnt != '0 ? r_mem[r_frp] : '0;
  assign rec_valid = r_fcnt != '0;
  assign rec_is_read = w_head.is_read;
  assign rec_addr = w_head.addr;
  assign rec_len = w_head.len;
  assign rec_id = w_head.id;
  assign rec_resp = w_head.resp;
  assign rec_beats = w_head.beats;
  assign rec_csum = w_head.csum;
  assign rec_ts = w_head.ts;
  assign err_proto = r_err_proto;
  assign err_ovf = r_err_ovf;
  assign drop_cnt = r_drop;
endmodule

// File: tb/tb_axi_txn_snoop_recorder.sv
// tb_axi_txn_snoop_recorder: table-driven vectors plus scoreboarded corner sequences for the AXI snoop recorder
module tb_axi_txn_snoop_recorder;
  logic aclk = 0, areset = 1;
  logic awvalid = 0, awready = 1, wvalid = 0, wready = 1, wlast = 0, bvalid = 0, bready = 1;
  logic arvalid = 0, arready = 1, rvalid = 0, rready = 1, rlast = 0, rec_ready = 0, err_clr = 0;
  logic [31:0] awaddr = 0, araddr = 0, wdata = 0, rdata = 0;
  logic [7:0] awlen = 0, arlen = 0;
  logic [3:0] awid = 0, bid = 0, arid = 0, rid = 0;
  logic [1:0] bresp = 0, rresp = 0;
  logic rec_valid, rec_is_read, err_proto, err_ovf;
  logic [31:0] rec_addr, rec_csum, rec_ts;
  logic [7:0] rec_len;
  logic [3:0] rec_id;
  logic [1:0] rec_resp;
  logic [8:0] rec_beats;
  logic [15:0] drop_cnt;
  int n_pass = 0, n_tot = 0;
  logic [31:0] cyc, last_ts;

  typedef struct {
    bit rd; logic [31:0] addr; logic [7:0] len; logic [3:0] id; int nb; logic [31:0] d0; int rot;
    logic [1:0] ra, rb; logic [3:0] rid; logic [8:0] eb; logic [31:0] ecs; logic [1:0] er; bit ee;
  } vec_t;
  typedef struct {
    bit rd; logic [31:0] addr; logic [7:0] len; logic [3:0] id; logic [1:0] resp;
    logic [8:0] beats; logic [31:0] csum; logic [31:0] ts;
  } exp_t;
  exp_t sb[$];

  axi_txn_snoop_recorder dut (
    .aclk(aclk), .areset(areset),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen), .awid(awid),
    .wvalid(wvalid), .wready(wready), .wlast(wlast), .wdata(wdata),
    .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen), .arid(arid),
    .rvalid(rvalid), .rready(rready), .rlast(rlast), .rdata(rdata), .rresp(rresp), .rid(rid),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_is_read(rec_is_read), .rec_addr(rec_addr),
    .rec_len(rec_len), .rec_id(rec_id), .rec_resp(rec_resp), .rec_beats(rec_beats),
    .rec_csum(rec_csum), .rec_ts(rec_ts), .err_proto(err_proto), .err_ovf(err_ovf),
    .drop_cnt(drop_cnt), .err_clr(err_clr));

  always #5 aclk = ~aclk;

  always @(posedge aclk or posedge areset)
    if (areset) cyc <= 0;
    else cyc <= cyc + 1;

  function automatic logic [31:0] exp_ts(input logic [31:0] t);
`ifdef TXN_TIMESTAMP_EN
    return t;
`else
    return t & 32'h0;
`endif
  endfunction

  function automatic logic [31:0] rotl(input logic [31:0] d, input int r);
    int s = r % 32;
    return s == 0 ? d : (d << s) | (d >> (32 - s));
  endfunction

  function automatic logic [127:0] rec_act();
    return {8'b0, rec_is_read, rec_addr, rec_len, rec_id, rec_resp, rec_beats, rec_csum, rec_ts};
  endfunction

  function automatic logic [127:0] exp_pack(input exp_t e);
    return {8'b0, e.rd, e.addr, e.len, e.id, e.resp, e.beats, e.csum, e.ts};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic push_exp(input bit rd, input logic [31:0] a, input logic [7:0] l, input logic [3:0] id,
                          input logic [1:0] resp, input logic [8:0] nb, input logic [31:0] cs, input logic [31:0] ts);
    exp_t e;
    e.rd = rd; e.addr = a; e.len = l; e.id = id; e.resp = resp; e.beats = nb; e.csum = cs; e.ts = ts;
    sb.push_back(e);
  endtask

  task automatic aw_beat(input logic [31:0] a, input logic [7:0] l, input logic [3:0] id);
    @(negedge aclk); awvalid = 1; awaddr = a; awlen = l; awid = id; last_ts = cyc;
    @(negedge aclk); awvalid = 0;
  endtask

  task automatic ar_beat(input logic [31:0] a, input logic [7:0] l, input logic [3:0] id);
    @(negedge aclk); arvalid = 1; araddr = a; arlen = l; arid = id; last_ts = cyc;
    @(negedge aclk); arvalid = 0;
  endtask

  task automatic w_beat(input logic [31:0] d, input bit last);
    @(negedge aclk); wvalid = 1; wdata = d; wlast = last;
    @(negedge aclk); wvalid = 0; wlast = 0;
  endtask

  task automatic r_beat(input logic [31:0] d, input logic [1:0] resp, input logic [3:0] id, input bit last);
    @(negedge aclk); rvalid = 1; rdata = d; rresp = resp; rid = id; rlast = last;
    @(negedge aclk); rvalid = 0; rlast = 0;
  endtask

  task automatic b_beat(input logic [3:0] id, input logic [1:0] resp);
    @(negedge aclk); bvalid = 1; bid = id; bresp = resp;
    @(negedge aclk); bvalid = 0;
  endtask

  task automatic drain_n(input int n, input string nm);
    exp_t e;
    int t;
    for (int k = 0; k < n; k++) begin
      t = 0;
      while (!rec_valid && t < 20) begin @(negedge aclk); t++; end
      chk({nm, "_valid"}, 128'(rec_valid), 128'(1));
      e = sb.pop_front();
      chk(nm, rec_act(), exp_pack(e));
      rec_ready = 1;
      @(negedge aclk); rec_ready = 0;
    end
  endtask

  task automatic drain(input string nm);
    drain_n(sb.size(), nm);
    chk({nm, "_empty"}, 128'(rec_valid), 128'(0));
  endtask

  task automatic clear_errs();
    @(negedge aclk); err_clr = 1;
    @(negedge aclk); err_clr = 0;
  endtask

  initial begin
    vec_t v[7];
    exp_t e;
    v[0] = '{1'b0, 32'h1000, 8'd3, 4'd2, 4, 32'h1,        1,  2'd0, 2'd0, 4'd2, 9'd4, 32'h0000000F, 2'd0, 1'b0};
    v[1] = '{1'b1, 32'h2000, 8'd1, 4'd5, 2, 32'hAAAA0000, 16, 2'd0, 2'd2, 4'd5, 9'd2, 32'hAAAAAAAA, 2'd2, 1'b0};
    v[2] = '{1'b0, 32'h3000, 8'd3, 4'd2, 2, 32'h10,       4,  2'd0, 2'd0, 4'd2, 9'd2, 32'h00000110, 2'd0, 1'b1};
    v[3] = '{1'b0, 32'h4000, 8'd0, 4'd2, 1, 32'h12345678, 0,  2'd0, 2'd0, 4'd3, 9'd1, 32'h12345678, 2'd0, 1'b1};
    v[4] = '{1'b1, 32'h5000, 8'd2, 4'd1, 3, 32'hF0F0F0F0, 4,  2'd1, 2'd0, 4'd1, 9'd3, 32'h0F0F0F0F, 2'd1, 1'b0};
    v[5] = '{1'b1, 32'h6000, 8'd0, 4'd7, 1, 32'hDEADBEEF, 0,  2'd0, 2'd3, 4'd6, 9'd1, 32'hDEADBEEF, 2'd3, 1'b1};
    v[6] = '{1'b0, 32'h7000, 8'd1, 4'd0, 2, 32'h80000001, 1,  2'd0, 2'd2, 4'd0, 9'd2, 32'h80000002, 2'd2, 1'b0};
    repeat (3) @(negedge aclk);
    chk("reset_state", {rec_act(), rec_valid, err_proto, err_ovf, drop_cnt}, '0);
    areset = 0;
    for (int i = 0; i < 7; i++) begin
      if (v[i].rd) begin
        ar_beat(v[i].addr, v[i].len, v[i].id);
        push_exp(1'b1, v[i].addr, v[i].len, v[i].rid, v[i].er, v[i].eb, v[i].ecs, exp_ts(last_ts));
        for (int k = 0; k < v[i].nb; k++)
          r_beat(rotl(v[i].d0, k * v[i].rot), k == v[i].nb - 1 ? v[i].rb : v[i].ra, v[i].rid, k == v[i].nb - 1);
      end else begin
        aw_beat(v[i].addr, v[i].len, v[i].id);
        push_exp(1'b0, v[i].addr, v[i].len, v[i].rid, v[i].rb, v[i].eb, v[i].ecs, exp_ts(last_ts));
        for (int k = 0; k < v[i].nb; k++) w_beat(rotl(v[i].d0, k * v[i].rot), k == v[i].nb - 1);
        b_beat(v[i].rid, v[i].rb);
      end
      drain($sformatf("vec%0d_rec", i));
      chk($sformatf("vec%0d_err_proto", i), 128'(err_proto), 128'(v[i].ee));
      if (v[i].ee) begin
        clear_errs();
        chk($sformatf("vec%0d_err_clr", i), 128'(err_proto), 128'(0));
      end
    end
    w_beat(32'h11, 1'b0);
    w_beat(32'h22, 1'b1);
    aw_beat(32'h8000, 8'd1, 4'd3);
    push_exp(1'b0, 32'h8000, 8'd1, 4'd3, 2'd0, 9'd2, 32'h33, exp_ts(last_ts));
    b_beat(4'd3, 2'd0);
    drain("w_first_rec");
    chk("w_first_err_proto", 128'(err_proto), 128'(0));
    for (int k = 0; k < 9; k++) begin
      aw_beat(32'hC000 + 32'(k * 16), 8'd0, 4'd1);
      if (k < 8) push_exp(1'b0, 32'hC000 + 32'(k * 16), 8'd0, 4'd1, 2'd0, 9'd1, 32'(k + 1), exp_ts(last_ts));
      w_beat(32'(k + 1), 1'b1);
      b_beat(4'd1, 2'd0);
    end
    chk("ovf_drop_cnt", 128'(drop_cnt), 128'(1));
    chk("ovf_err_ovf", 128'(err_ovf), 128'(1));
    chk("ovf_err_proto", 128'(err_proto), 128'(0));
    drain_n(1, "ovf_rec");
    aw_beat(32'hD000, 8'd0, 4'd6);
    push_exp(1'b0, 32'hD000, 8'd0, 4'd6, 2'd0, 9'd1, 32'h77, exp_ts(last_ts));
    w_beat(32'h77, 1'b1);
    ar_beat(32'hE000, 8'd0, 4'd7);
    @(negedge aclk); bvalid = 1; bid = 6; bresp = 0; rvalid = 1; rlast = 1; rid = 7; rdata = 32'h99; rresp = 0;
    @(negedge aclk); bvalid = 0; rvalid = 0; rlast = 0;
    chk("sim_drop_cnt", 128'(drop_cnt), 128'(2));
    chk("sim_err_ovf", 128'(err_ovf), 128'(1));
    chk("sim_err_proto", 128'(err_proto), 128'(0));
    aw_beat(32'hF000, 8'd0, 4'd8);
    w_beat(32'h5A, 1'b1);
    e = sb.pop_front();
    chk("pop_head", rec_act(), exp_pack(e));
    push_exp(1'b0, 32'hF000, 8'd0, 4'd8, 2'd0, 9'd1, 32'h5A, exp_ts(last_ts));
    @(negedge aclk); bvalid = 1; bid = 8; bresp = 0; rec_ready = 1;
    @(negedge aclk); bvalid = 0; rec_ready = 0;
    chk("pop_free_drop_cnt", 128'(drop_cnt), 128'(2));
    drain("full_rec");
    clear_errs();
    chk("clr_drop_cnt", 128'(drop_cnt), 128'(0));
    chk("clr_err_ovf", 128'(err_ovf), 128'(0));
    aw_beat(32'h9000, 8'd0, 4'd1);
    w_beat(32'h55, 1'b1);
    b_beat(4'd2, 2'd0);
    aw_beat(32'hA000, 8'd3, 4'd4);
    w_beat(32'h1, 1'b0);
    w_beat(32'h2, 1'b0);
    chk("pre_reset_busy", {128'(rec_valid), 128'(err_proto)} == 0 ? 128'(0) : 128'(1), 128'(1));
    @(negedge aclk); areset = 1;
    @(negedge aclk);
    chk("mid_reset_outputs", {rec_act(), rec_valid, err_proto, err_ovf, drop_cnt}, '0);
    areset = 0;
    sb.delete();
    aw_beat(32'hB000, 8'd3, 4'd4);
    push_exp(1'b0, 32'hB000, 8'd3, 4'd4, 2'd0, 9'd4, 32'h03030303, exp_ts(last_ts));
    for (int k = 0; k < 4; k++) w_beat(rotl(32'h3, k * 8), k == 3);
    b_beat(4'd4, 2'd0);
    drain("post_reset_rec");
    chk("post_reset_err_proto", 128'(err_proto), 128'(0));
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/axi_txn_snoop_recorder.md
Name: axi_txn_snoop_recorder

Overview:
- Passive, synthesizable AXI4 bus snooper placed on the link between the passthrough VIP and the slave VIP inside `chip`.
- Never drives the bus; it only observes the handshakes.
- Condenses each completed write (AW+W+B) and each completed read (AR+R) into a single record, buffered in a FIFO.
- An on-chip or bench consumer drains the FIFO for hardware-side scoreboarding alongside the VIP monitors.

Parameters:
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width; must be a multiple of 32.
- ID_WIDTH, 4, AXI ID width.
- CMD_DEPTH, 4, depth of the AW, AR and write-data-summary queues; power of 2.
- REC_DEPTH, 8, record FIFO depth; power of 2, ≥2.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- areset  in  1  asynchronous, active-high reset.
- awvalid/awready  in  1 each  AW handshake.
- awaddr  in  ADDR_WIDTH.
- awlen  in  8.
- awid  in  ID_WIDTH.
- wvalid/wready/wlast  in  1 each.
- wdata  in  DATA_WIDTH.
- bvalid/bready  in  1 each.
- bresp  in  2.
- bid  in  ID_WIDTH.
- arvalid/arready  in  1 each.
- araddr  in  ADDR_WIDTH.
- arlen  in  8.
- arid  in  ID_WIDTH.
- rvalid/rready/rlast  in  1 each.
- rdata  in  DATA_WIDTH.
- rresp  in  2.
- rid  in  ID_WIDTH.
- rec_valid  out  1  record FIFO non-empty.
- rec_ready  in  1  consumer pop.
- rec_is_read  out  1.
- rec_addr  out  ADDR_WIDTH.
- rec_len  out  8  AxLEN of the command.
- rec_id  out  ID_WIDTH.
- rec_resp  out  2.
- rec_beats  out  9  data beats actually observed.
- rec_csum  out  32  XOR checksum of the data.
- rec_ts  out  32  timestamp (optional feature).
- err_proto  out  1  sticky protocol error.
- err_ovf  out  1  sticky record drop.
- drop_cnt  out  16  dropped records, saturating.
- err_clr  in  1  synchronous clear of err_proto, err_ovf and drop_cnt.

Behaviour:
- Reset:
  - All queues and FIFO empty; beat counters and checksum accumulators zero.
  - All outputs 0.
  - A reset mid-burst discards partial bursts and all queued commands.
- Handshake: a beat occurs when valid && ready in the same cycle. The block has no outputs onto the bus.
- Checksum: fold each beat by XOR-ing its DATA_WIDTH/32 words, then XOR the folded value into the burst accumulator. Accumulator is 0 at burst start.
- Write path:
  - AW beat pushes {awaddr, awlen, awid, ts} into AWQ.
  - W beats increment wcnt and update the checksum independently of AW, so W may precede AW.
  - wlast beat pushes {wcnt+1, csum} into WSQ; the counter and accumulator then restart at zero.
  - B beat pops the AWQ front and WSQ front and forms the record: resp=bresp, id=bid.
  - err_proto is set if any of these hold:
    - bid ≠ AWQ.id;
    - beats ≠ len+1;
    - AWQ or WSQ is empty at the B beat — the record is still produced with beats=0, csum=0 and addr/len from AWQ if present, else 0.
- Read path:
  - AR beat pushes ARQ.
  - R beats count and update the checksum; resp accumulates as the max rresp seen in the burst.
  - rlast beat pops ARQ and forms the record.
  - err_proto is set if rid ≠ ARQ.id, beats ≠ len+1, or ARQ is empty.
- Ordering: only in-order completion is supported. Out-of-order IDs are reported as err_proto.
- Queue full: a push into a full AWQ, ARQ or WSQ is dropped and sets err_proto.
- Latency: a record is visible on rec_valid the cycle after the completing B or rlast beat. rec_* shows the FIFO head (first-word fall-through).
- Simultaneous completions: the FIFO accepts up to two pushes per cycle; the write record goes in ahead of the read record.
  - If only one slot is free, the write record is stored and the read record is dropped.
  - If no slot is free, both are dropped.
  - Each dropped record increments drop_cnt (saturating at 0xFFFF) and sets err_ovf.
  - A pop in the same cycle frees its slot before the space check.
- err_clr together with a new error in the same cycle: the error wins, and the bit is set.

Optional Feature:
- TXN_TIMESTAMP_EN defined:
  - A 32-bit free-running cycle counter (reset 0, wraps at 2^32) is sampled at the AW/AR beat.
  - rec_ts carries that sample.
- Not defined: no counter is built and rec_ts is tied to 0.

Test Plan:
- Single write:
  - Stimulus: AW addr=0x1000, len=3, id=2; W data 0x1, 0x2, 0x4, 0x8; B OKAY.
  - Response: one record with is_read=0, beats=4, csum=0xF, resp=0, err_proto=0.
- Read burst:
  - Stimulus: AR addr=0x2000, len=1, id=5; R 0xAAAA0000 OKAY, then 0x0000AAAA SLVERR with rlast.
  - Response: record with is_read=1, csum=0xAAAAAAAA, resp=2, beats=2.
- W before AW:
  - Stimulus: 2 W beats with wlast, then AW len=1, then B.
  - Response: correct record; err_proto stays 0.
- Protocol errors:
  - Stimulus 1: wlast asserted on beat 2 of a len=3 write.
  - Response 1: err_proto=1, beats=2.
  - Stimulus 2: bid=3 against awid=2.
  - Response 2: err_proto=1.
  - Then pulse err_clr → err_proto=0.
- Overflow:
  - Stimulus: hold rec_ready=0 and complete 9 writes with REC_DEPTH=8.
  - Response: 8 records stored, drop_cnt=1, err_ovf=1.
  - Also: with 1 slot free, complete a write and a read in the same cycle → write stored, read dropped, drop_cnt increments.
- Reset and timestamp:
  - Stimulus: assert areset mid-burst, after 2 of 4 W beats.
  - Response: all outputs 0; the next full write yields beats=4.
  - With TXN_TIMESTAMP_EN: rec_ts equals the cycle index of the AW beat counted from reset release.
